// File: rtl/leiwand_rv32_wb_arbiter_pkg.sv
// Shared arbiter state encodings, parameter defaults and width helper.
package leiwand_rv32_wb_arbiter_pkg;

  localparam int MEM_WIDTH_DEF       = 32;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF  = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2,
    ARB_ERR  = 2'd3
  } arb_state_e;

  // Highest bit index a counter needs to hold values 0..v (v >= 1).
  function automatic int high_bit_to_fit(input int v);
    return $clog2(v + 1) - 1;
  endfunction

endpackage

// File: rtl/leiwand_rv32_wb_watchdog.sv
// Outstanding-strobe tracker and no-ack timeout for the current grant.
module leiwand_rv32_wb_watchdog
  import leiwand_rv32_wb_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_stb_accept,
  input  logic i_ack,
  input  logic i_clear,
  output logic o_full,
  output logic o_expired
);

  localparam int OB = high_bit_to_fit(MAX_OUTSTANDING);
  localparam int TB = high_bit_to_fit(TIMEOUT_CYCLES);
  localparam logic [OB:0] MAX_V  = (OB+1)'(MAX_OUTSTANDING);
  localparam logic [OB:0] O_ONE  = (OB+1)'(1);
  localparam logic [TB:0] TO_V   = (TB+1)'(TIMEOUT_CYCLES);
  localparam logic [TB:0] TO_LST = (TB+1)'(TIMEOUT_CYCLES - 1);
  localparam logic [TB:0] T_ONE  = (TB+1)'(1);

  logic [OB:0] r_outst;
  logic [TB:0] r_tcnt;
  logic        w_busy, w_inc, w_dec;

  assign w_busy = (r_outst != '0);
  assign o_full = (r_outst == MAX_V);
  // An ack with nothing outstanding is passed on by the arbiter but never underflows us.
  assign w_inc  = i_stb_accept & ~o_full;
  assign w_dec  = i_ack & w_busy;
  // Fires on the cycle that would bring the no-ack count up to the limit.
  assign o_expired = w_busy & ~i_ack & ~i_clear & (r_tcnt >= TO_LST);

  // Outstanding count: accept and ack in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_outst <= '0;
    else if (i_clear)          r_outst <= '0;
    else if (w_inc && !w_dec)  r_outst <= r_outst + O_ONE;
    else if (w_dec && !w_inc)  r_outst <= r_outst - O_ONE;
  end

  // Consecutive cycles waiting on an ack; saturates at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_tcnt <= '0;
    else if (i_clear || i_ack || !w_busy) r_tcnt <= '0;
    else if (r_tcnt != TO_V)             r_tcnt <= r_tcnt + T_ONE;
  end

endmodule

// File: rtl/leiwand_rv32_wb_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter, round-robin per cyc burst.
module leiwand_rv32_wb_arbiter
  import leiwand_rv32_wb_arbiter_pkg::*;
#(
  parameter int MEM_WIDTH       = MEM_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [MEM_WIDTH-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_data_out,
  output logic [MEM_WIDTH-1:0] m0_data_in,
  output logic                 m0_ack,
  output logic                 m0_stall,
  output logic                 m0_err,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [MEM_WIDTH-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_data_out,
  output logic [MEM_WIDTH-1:0] m1_data_in,
  output logic                 m1_ack,
  output logic                 m1_stall,
  output logic                 m1_err,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [MEM_WIDTH-1:0] s_addr,
  output logic [MEM_WIDTH-1:0] s_data_out,
  input  logic [MEM_WIDTH-1:0] s_data_in,
  input  logic                 s_ack,
  input  logic                 s_stall
);

  arb_state_e r_state;
  logic       r_last;     // master granted most recently; error target in ARB_ERR

  logic                 w_gnt0, w_gnt1, w_gnt;
  logic                 w_own_cyc, w_own_stb, w_own_we;
  logic [MEM_WIDTH-1:0] w_own_addr, w_own_dat;
  logic                 w_full, w_expired, w_accept, w_ack_fwd, w_clear, w_err;

  assign w_gnt0 = (r_state == ARB_GNT0);
  assign w_gnt1 = (r_state == ARB_GNT1);
  assign w_gnt  = w_gnt0 | w_gnt1;
  assign w_err  = (r_state == ARB_ERR);

  // Owner request mux; everything reads as zero while nobody holds the grant.
  always_comb begin
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_we   = 1'b0;
    w_own_addr = '0;
    w_own_dat  = '0;
    if (w_gnt0) begin
      w_own_cyc = m0_cyc; w_own_stb = m0_stb; w_own_we = m0_we;
      w_own_addr = m0_addr; w_own_dat = m0_data_out;
    end else if (w_gnt1) begin
      w_own_cyc = m1_cyc; w_own_stb = m1_stb; w_own_we = m1_we;
      w_own_addr = m1_addr; w_own_dat = m1_data_out;
    end
  end

  assign s_cyc      = w_own_cyc;
  assign s_stb      = w_own_cyc & w_own_stb & ~w_full;
  assign s_we       = w_own_we;
  assign s_addr     = w_own_addr;
  assign s_data_out = w_own_dat;

  assign w_accept  = s_stb & ~s_stall;
  // Acks seen after the owner drops cyc belong to an abandoned burst.
  assign w_ack_fwd = s_ack & w_own_cyc;
  assign w_clear   = ~w_own_cyc;

  assign m0_ack     = w_gnt0 & w_ack_fwd;
  assign m1_ack     = w_gnt1 & w_ack_fwd;
  assign m0_data_in = w_gnt0 ? s_data_in : '0;
  assign m1_data_in = w_gnt1 ? s_data_in : '0;
  assign m0_stall   = w_gnt0 ? (s_stall | w_full) : 1'b1;
  assign m1_stall   = w_gnt1 ? (s_stall | w_full) : 1'b1;
  assign m0_err     = w_err & ~r_last;
  assign m1_err     = w_err &  r_last;

  leiwand_rv32_wb_watchdog #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_wd (
    .clk          (clk),
    .reset        (reset),
    .i_stb_accept (w_accept),
    .i_ack        (w_ack_fwd),
    .i_clear      (w_clear),
    .o_full       (w_full),
    .o_expired    (w_expired)
  );

  // Grant FSM: last grant recorded at grant time, so a tie goes to the other master.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (m0_cyc && (!m1_cyc || r_last)) begin
            r_state <= ARB_GNT0;
            r_last  <= 1'b0;
          end else if (m1_cyc) begin
            r_state <= ARB_GNT1;
            r_last  <= 1'b1;
          end
        end
        ARB_GNT0, ARB_GNT1: begin
          if (!w_own_cyc)     r_state <= ARB_IDLE;
          else if (w_expired) r_state <= ARB_ERR;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_arbiter.sv
// Directed bench for the two-master Wishbone arbiter (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=8).
module tb_leiwand_rv32_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_data_out, m1_addr, m1_data_out;
  logic [31:0] m0_data_in, m1_data_in;
  logic        m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err;
  logic        s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [31:0] s_addr, s_data_out, s_data_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  leiwand_rv32_wb_arbiter #(
    .MEM_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_data_out(m0_data_out), .m0_data_in(m0_data_in),
    .m0_ack(m0_ack), .m0_stall(m0_stall), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_data_out(m1_data_out), .m1_data_in(m1_data_in),
    .m1_ack(m1_ack), .m1_stall(m1_stall), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_data_out(s_data_out), .s_data_in(s_data_in),
    .s_ack(s_ack), .s_stall(s_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acks;

  initial begin
    reset = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = 32'h1000_0000; m0_data_out = 32'h0;
    m1_cyc = 1'b1; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = 32'h2000_0000; m1_data_out = 32'h0;
    s_ack = 1'b0; s_stall = 1'b0; s_data_in = 32'h0;

    // Reset held with both masters requesting.
    step(); step();
    chk("rst_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("rst_m0_stall", {31'b0, m0_stall}, 32'd1);
    chk("rst_m1_stall", {31'b0, m1_stall}, 32'd1);
    chk("rst_m0_err", {31'b0, m0_err}, 32'd0);
    reset = 1'b1;
    step();
    // Tie after reset goes to master 0.
    chk("gnt0_s_cyc", {31'b0, s_cyc}, 32'd1);
    chk("gnt0_s_addr", s_addr, 32'h1000_0000);
    chk("gnt0_m1_stall", {31'b0, m1_stall}, 32'd1);

    // Two reads by m0.
    m0_stb = 1'b1; m0_addr = 32'h0000_0100;
    #1 chk("rd1_s_stb", {31'b0, s_stb}, 32'd1);
    step();
    m0_addr = 32'h0000_0104; s_ack = 1'b1; s_data_in = 32'h42;
    #1 chk("rd1_ack", {31'b0, m0_ack}, 32'd1);
    chk("rd1_data", m0_data_in, 32'h42);
    chk("rd1_m1_data", m1_data_in, 32'h0);
    step();
    m0_stb = 1'b0; s_data_in = 32'h43;
    #1 chk("rd2_data", m0_data_in, 32'h43);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0;
    #1 chk("drop_s_cyc", {31'b0, s_cyc}, 32'd0);
    step();
    // Dead arbitration cycle.
    chk("idle_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("idle_m1_stall", {31'b0, m1_stall}, 32'd1);
    step();
    chk("gnt1_s_addr", s_addr, 32'h2000_0000);
    chk("gnt1_m1_stall", {31'b0, m1_stall}, 32'd0);
    chk("gnt1_m0_stall", {31'b0, m0_stall}, 32'd1);
    m1_cyc = 1'b0; m0_cyc = 1'b1; m0_addr = 32'h1000_0000;
    step();
    m1_cyc = 1'b1;
    #1 chk("rr_idle_s_cyc", {31'b0, s_cyc}, 32'd0);
    step();
    // Tie again: master 1 was last, so master 0 wins.
    chk("rr_m0_stall", {31'b0, m0_stall}, 32'd0);
    chk("rr_m1_stall", {31'b0, m1_stall}, 32'd1);
    chk("rr_s_addr", s_addr, 32'h1000_0000);
    step();

    // Outstanding cap: 6 strobes, first ack 5 cycles after the first strobe
    // (kept under the 8-cycle timeout). The slot freed by the ack in cycle 5
    // is usable from cycle 6.
    for (int k = 0; k <= 11; k++) begin
      m0_stb = (k <= 7);
      s_ack  = (k >= 5 && k <= 10);
      s_data_in = 32'h200 + k;
      #1;
      chk($sformatf("cap_s_stb_%0d", k), {31'b0, s_stb}, {31'b0, (k < 4) || k == 6 || k == 7});
      chk($sformatf("cap_stall_%0d", k), {31'b0, m0_stall}, {31'b0, k == 4 || k == 5});
      chk($sformatf("cap_ack_%0d", k), {31'b0, m0_ack}, {31'b0, k >= 5 && k <= 10});
      chk($sformatf("cap_err_%0d", k), {31'b0, m0_err}, 32'd0);
      step();
    end

    // Steady stream: one new strobe and one ack every cycle.
    acks = 0;
    for (int j = 0; j <= 20; j++) begin
      m0_stb = (j < 20);
      s_ack  = (j >= 1);
      #1;
      if (m0_ack) acks++;
      chk($sformatf("str_stall_%0d", j), {31'b0, m0_stall}, 32'd0);
      chk($sformatf("str_err_%0d", j), {31'b0, m0_err}, 32'd0);
      step();
    end
    chk("str_acks", acks, 32'd20);

    // Timeout on master 1.
    m0_stb = 1'b0; m0_cyc = 1'b0; s_ack = 1'b0;
    step();
    step();
    m1_stb = 1'b1; m1_addr = 32'h2000_0040;
    #1 chk("to_accept", {31'b0, s_stb}, 32'd1);
    step();
    m1_stb = 1'b0;
    // The accepting edge closes cycle 0; err must show in cycle 9,
    // i.e. eight edges after the acceptance edge.
    for (int n = 1; n <= 8; n++) begin
      #1;
      chk($sformatf("to_wait_err_%0d", n), {31'b0, m1_err}, 32'd0);
      chk($sformatf("to_wait_cyc_%0d", n), {31'b0, s_cyc}, 32'd1);
      step();
    end
    chk("to_err", {31'b0, m1_err}, 32'd1);
    chk("to_err_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("to_err_m0", {31'b0, m0_err}, 32'd0);
    chk("to_err_ack", {31'b0, m1_ack}, 32'd0);
    m1_cyc = 1'b0;
    step();
    s_ack = 1'b1;
    #1 chk("late_m1_ack", {31'b0, m1_ack}, 32'd0);
    chk("late_m0_ack", {31'b0, m0_ack}, 32'd0);
    chk("late_err_once", {31'b0, m1_err}, 32'd0);
    step();

    // Mid-burst reset with two strobes outstanding on master 1.
    s_ack = 1'b0; m1_cyc = 1'b1;
    step();
    m1_stb = 1'b1;
    step();
    step();
    m0_cyc = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mrst_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("mrst_s_stb", {31'b0, s_stb}, 32'd0);
    chk("mrst_s_addr", s_addr, 32'h0);
    chk("mrst_m1_stall", {31'b0, m1_stall}, 32'd1);
    step();
    reset = 1'b1; m1_stb = 1'b0;
    step();
    chk("mrst_gnt0", {31'b0, m0_stall}, 32'd0);
    chk("mrst_m1_wait", {31'b0, m1_stall}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
